// File: rtl/tile_fetch_pkg.sv
// Shared definitions for the tile fetch engine.
//   - fetch_state_e : engine FSM states
//   - CH_*          : default logical buffer IDs
//   - BASE_*        : default region base addresses for config tie-off
//   - ch_width()    : channel-select width, never narrower than 1 bit
package tile_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } fetch_state_e;

    localparam int unsigned CH_WEIGHT = 0;
    localparam int unsigned CH_KMAT   = 1;
    localparam int unsigned CH_VMAT   = 2;

    localparam int unsigned BASE_WEIGHT = 0;
    localparam int unsigned BASE_KMAT   = 4;
    localparam int unsigned BASE_VMAT   = 772;

    function automatic int unsigned ch_width(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/tile_fetch_engine_rd_pipe.sv
// rd_latency_pipe: tags BRAM reads with {valid,last} and delays them by the
// BRAM read latency so they line up with the returned data.
//   clk_i, rst_ni      : clock, async active-low reset (clears all stages)
//   valid_i, last_i    : tag of the read issued this cycle
//   valid_o, last_o    : tag of the read whose data returns this cycle
module rd_latency_pipe #(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid_i,
    input  logic last_i,
    output logic valid_o,
    output logic last_o
);

    logic [RD_LATENCY-1:0] valid_q, valid_d;
    logic [RD_LATENCY-1:0] last_q, last_d;

    always_comb begin
        valid_d    = valid_q << 1;
        last_d     = last_q << 1;
        valid_d[0] = valid_i;
        last_d[0]  = last_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            last_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q[RD_LATENCY-1];
    assign last_o  = last_q[RD_LATENCY-1];

endmodule

// File: rtl/tile_fetch_engine.sv
// tile_fetch_engine: issues a burst of BRAM reads for the next tile of a
// selected logical buffer and returns the read data tagged valid/last.
//   clk_i, rst_ni        : clock, async active-low reset
//   start_fetch_i        : request to fetch next tile of ch_sel_i (IDLE only)
//   ch_sel_i, fetch_len_i: channel and words per tile
//   cfg_base_i           : flattened per-channel region base addresses
//   cfg_num_tiles_i      : flattened per-channel tile counts (pointer wrap)
//   reset_ptrs_i         : per-channel tile pointer clear
//   bram_addr_o/en_o     : BRAM read port, bram_rdata_i returns RD_LATENCY later
//   out_data_o/valid_o/last_o/ch_o : returned tile words
//   busy_o, fetch_done_o, fetch_err_o : status
module tile_fetch_engine
    import tile_fetch_pkg::*;
#(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned PTR_WIDTH  = 9,
    parameter int unsigned LEN_WIDTH  = 4,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned CH_W       = ch_width(NUM_CH)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_fetch_i,
    input  logic [CH_W-1:0]              ch_sel_i,
    input  logic [LEN_WIDTH-1:0]         fetch_len_i,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] cfg_base_i,
    input  logic [NUM_CH*PTR_WIDTH-1:0]  cfg_num_tiles_i,
    input  logic [NUM_CH-1:0]            reset_ptrs_i,
    output logic [ADDR_WIDTH-1:0]        bram_addr_o,
    output logic                         bram_en_o,
    input  logic [DATA_WIDTH-1:0]        bram_rdata_i,
    output logic [DATA_WIDTH-1:0]        out_data_o,
    output logic                         out_valid_o,
    output logic                         out_last_o,
    output logic [CH_W-1:0]              out_ch_o,
    output logic                         busy_o,
    output logic                         fetch_done_o,
    output logic                         fetch_err_o
);

    localparam int unsigned ProdWidth = PTR_WIDTH + LEN_WIDTH;

    fetch_state_e           state_q, state_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   offset_q, offset_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [PTR_WIDTH-1:0]   ntiles_q, ntiles_d;
    logic                   err_q, err_d;
    logic [PTR_WIDTH-1:0]   ptr_q [NUM_CH];
    logic [PTR_WIDTH-1:0]   ptr_d [NUM_CH];

    logic                   ch_valid;
    logic [ADDR_WIDTH-1:0]  sel_base;
    logic [PTR_WIDTH-1:0]   sel_ptr;
    logic [PTR_WIDTH-1:0]   sel_ntiles;
    logic [ProdWidth-1:0]   tile_prod;
    logic [ADDR_WIDTH-1:0]  tile_base;
    logic                   reject;
    logic                   last_issue;
    logic                   pipe_valid;
    logic                   pipe_last;
    logic                   enter_done;

    // Per-channel config/pointer lookup for the requested channel.
    always_comb begin
        ch_valid   = 1'b0;
        sel_base   = '0;
        sel_ptr    = '0;
        sel_ntiles = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(ch_sel_i) == i) begin
                ch_valid   = 1'b1;
                sel_base   = cfg_base_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_ptr    = ptr_q[i];
                sel_ntiles = cfg_num_tiles_i[i*PTR_WIDTH +: PTR_WIDTH];
            end
        end
    end

    // Full-width product, then modulo 2^ADDR_WIDTH on the add.
    assign tile_prod = ProdWidth'(sel_ptr) * ProdWidth'(fetch_len_i);
    assign tile_base = sel_base + ADDR_WIDTH'(tile_prod);

    assign reject     = !ch_valid || (fetch_len_i == '0) || (sel_ntiles == '0);
    assign last_issue = (state_q == StIssue) && (offset_q == (len_q - LEN_WIDTH'(1)));

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        len_d       = len_q;
        offset_d    = offset_q;
        base_d      = base_q;
        ntiles_d    = ntiles_q;
        err_d       = 1'b0;
        bram_en_o   = 1'b0;
        bram_addr_o = '0;
        unique case (state_q)
            StIdle: begin
                if (start_fetch_i) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = StIssue;
                        ch_d     = ch_sel_i;
                        len_d    = fetch_len_i;
                        offset_d = '0;
                        base_d   = tile_base;
                        ntiles_d = sel_ntiles;
                    end
                end
            end
            StIssue: begin
                bram_en_o   = 1'b1;
                bram_addr_o = base_q + ADDR_WIDTH'(offset_q);
                offset_d    = offset_q + LEN_WIDTH'(1);
                if (last_issue) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (pipe_valid && pipe_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign enter_done = (state_q == StDrain) && (state_d == StDone);

    // Advance the active channel's pointer on entry to DONE; a clear on the
    // same edge takes priority.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ptr_d[i] = ptr_q[i];
            if (enter_done && (32'(ch_q) == i)) begin
                if ((32'(ptr_q[i]) + 32'd1) >= 32'(ntiles_q)) begin
                    ptr_d[i] = '0;
                end else begin
                    ptr_d[i] = ptr_q[i] + PTR_WIDTH'(1);
                end
            end
            if (reset_ptrs_i[i]) begin
                ptr_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            ch_q     <= '0;
            len_q    <= '0;
            offset_q <= '0;
            base_q   <= '0;
            ntiles_q <= '0;
            err_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ptr_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            len_q    <= len_d;
            offset_q <= offset_d;
            base_q   <= base_d;
            ntiles_q <= ntiles_d;
            err_q    <= err_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ptr_q[i] <= ptr_d[i];
            end
        end
    end

    rd_latency_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (bram_en_o),
        .last_i  (last_issue),
        .valid_o (pipe_valid),
        .last_o  (pipe_last)
    );

    assign busy_o       = (state_q != StIdle);
    assign fetch_done_o = (state_q == StDone);
    assign fetch_err_o  = err_q;
    assign out_valid_o  = pipe_valid;
    assign out_last_o   = pipe_valid & pipe_last;
    // Data is forced to zero outside valid beats so all outputs read 0 in reset.
    assign out_data_o   = pipe_valid ? bram_rdata_i : '0;
    assign out_ch_o     = busy_o ? ch_q : '0;

endmodule

// File: tb/tb_tile_fetch_engine.sv
// Bench for tile_fetch_engine: two instances (read latency 1 and 3) share all
// stimulus; each has its own BRAM model whose data word encodes the address.
module tb_tile_fetch_engine;
    import tile_fetch_pkg::*;

    localparam int unsigned NCH = 3;
    localparam int unsigned AW  = 11;
    localparam int unsigned DW  = 256;
    localparam int unsigned PW  = 9;
    localparam int unsigned LW  = 4;
    localparam int unsigned CW  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                  start;
    logic [CW-1:0]         ch_sel;
    logic [LW-1:0]         flen;
    logic [NCH*AW-1:0]     cfg_base;
    logic [NCH*PW-1:0]     cfg_nt;
    logic [NCH-1:0]        rptr;

    logic [AW-1:0] addr  [2];
    logic          en    [2];
    logic [DW-1:0] rdata [2];
    logic [DW-1:0] odata [2];
    logic          ov    [2];
    logic          ol    [2];
    logic [CW-1:0] och   [2];
    logic          bsy   [2];
    logic          dn    [2];
    logic          er    [2];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    int unsigned m_ptr  [NCH];
    int unsigned m_base [NCH];
    int unsigned m_nt   [NCH];

    tile_fetch_engine #(.RD_LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_fetch_i(start), .ch_sel_i(ch_sel),
        .fetch_len_i(flen), .cfg_base_i(cfg_base), .cfg_num_tiles_i(cfg_nt),
        .reset_ptrs_i(rptr), .bram_addr_o(addr[0]), .bram_en_o(en[0]),
        .bram_rdata_i(rdata[0]), .out_data_o(odata[0]), .out_valid_o(ov[0]),
        .out_last_o(ol[0]), .out_ch_o(och[0]), .busy_o(bsy[0]),
        .fetch_done_o(dn[0]), .fetch_err_o(er[0])
    );

    tile_fetch_engine #(.RD_LATENCY(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .start_fetch_i(start), .ch_sel_i(ch_sel),
        .fetch_len_i(flen), .cfg_base_i(cfg_base), .cfg_num_tiles_i(cfg_nt),
        .reset_ptrs_i(rptr), .bram_addr_o(addr[1]), .bram_en_o(en[1]),
        .bram_rdata_i(rdata[1]), .out_data_o(odata[1]), .out_valid_o(ov[1]),
        .out_last_o(ol[1]), .out_ch_o(och[1]), .busy_o(bsy[1]),
        .fetch_done_o(dn[1]), .fetch_err_o(er[1])
    );

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = {a, 5'(i), 16'hC0DE};
        return w;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // BRAM models: address delayed by each instance's read latency.
    logic [AW-1:0] dl_addr [2][3];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            dl_addr[k][0] <= addr[k];
            for (int s = 1; s < 3; s++) dl_addr[k][s] <= dl_addr[k][s-1];
        end
    end
    always_comb begin
        rdata[0] = word_of(dl_addr[0][0]);
        rdata[1] = word_of(dl_addr[1][2]);
    end

    task automatic set_cfg();
        for (int c = 0; c < NCH; c++) begin
            cfg_base[c*AW +: AW] = AW'(m_base[c]);
            cfg_nt[c*PW +: PW]   = PW'(m_nt[c]);
        end
    endtask

    task automatic default_cfg(input int unsigned nt);
        m_base[0] = BASE_WEIGHT;
        m_base[1] = BASE_KMAT;
        m_base[2] = BASE_VMAT;
        for (int c = 0; c < NCH; c++) m_nt[c] = nt;
        set_cfg();
    endtask

    task automatic random_cfg();
        for (int c = 0; c < NCH; c++) begin
            m_base[c] = $urandom_range(0, 2047);
            m_nt[c]   = $urandom_range(1, 6);
        end
        set_cfg();
    endtask

    // One accepted fetch checked cycle by cycle against spec timing.
    // ign: a start pulse during ISSUE; clr: reset_ptrs[ch] around DONE;
    // scr: config rewritten mid-burst.
    task automatic run_fetch(input int ch, input int len, input bit ign, input bit clr,
                             input bit scr);
        int unsigned tb0, nt, lat, ea;
        bit e_en, e_val, e_last, e_done, e_busy;
        tb0 = (m_base[ch] + m_ptr[ch] * len) % 2048;
        nt  = m_nt[ch];
        @(posedge clk); #1;
        start = 1'b1; ch_sel = CW'(ch); flen = LW'(len);
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 1; j <= len + 6; j++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                lat    = lat_of(k);
                e_en   = (j <= len);
                e_val  = (j >= lat + 1) && (j <= lat + len);
                e_last = (j == lat + len);
                e_done = (j == len + lat + 1);
                e_busy = (j <= len + lat + 1);
                vectors++;
                if (en[k] !== e_en) begin
                    miscompares++;
                    $display("FAIL fetch.bram_en dut%0d ch%0d j=%0d got %b want %b", k, ch, j,
                             en[k], e_en);
                end
                if (e_en) begin
                    ea = (tb0 + j - 1) % 2048;
                    vectors++;
                    if (addr[k] !== AW'(ea)) begin
                        miscompares++;
                        $display("FAIL fetch.bram_addr dut%0d ch%0d j=%0d got %0d want %0d", k, ch,
                                 j, addr[k], ea);
                    end
                end
                vectors++;
                if (ov[k] !== e_val || ol[k] !== e_last) begin
                    miscompares++;
                    $display("FAIL fetch.valid_last dut%0d ch%0d j=%0d got %b%b want %b%b", k, ch,
                             j, ov[k], ol[k], e_val, e_last);
                end
                if (e_val) begin
                    ea = (tb0 + j - 1 - lat) % 2048;
                    vectors++;
                    if (odata[k] !== word_of(AW'(ea))) begin
                        miscompares++;
                        $display("FAIL fetch.out_data dut%0d j=%0d got %h want %h", k, j,
                                 odata[k][31:0], word_of(AW'(ea)) & 256'hFFFF_FFFF);
                    end
                end
                vectors++;
                if (dn[k] !== e_done || bsy[k] !== e_busy || er[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fetch.status dut%0d ch%0d j=%0d got done=%b busy=%b err=%b want %b %b 0",
                             k, ch, j, dn[k], bsy[k], er[k], e_done, e_busy);
                end
                if (e_busy) begin
                    vectors++;
                    if (och[k] !== CW'(ch)) begin
                        miscompares++;
                        $display("FAIL fetch.out_ch dut%0d j=%0d got %0d want %0d", k, j, och[k],
                                 ch);
                    end
                end
            end
            // Inputs for cycle j+1.
            start = ign && (j == 1);
            if (ign && j == 1) begin
                ch_sel = CW'($urandom_range(0, 2));
                flen   = LW'($urandom_range(1, 15));
            end
            rptr = (clr && j >= len && j <= len + 3) ? NCH'(1 << ch) : '0;
            if (scr && j == 2) random_cfg();
        end
        if (clr) m_ptr[ch] = 0;
        else m_ptr[ch] = (m_ptr[ch] + 1 >= nt) ? 0 : m_ptr[ch] + 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; ch_sel = '0; flen = '0; rptr = '0;
        for (int c = 0; c < NCH; c++) m_ptr[c] = 0;
        default_cfg(4);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({en[k], addr[k], ov[k], ol[k], och[k], bsy[k], dn[k], er[k]} !== '0) begin
                miscompares++;
                $display("FAIL reset.ctrl dut%0d got en=%b addr=%0d v=%b l=%b ch=%0d busy=%b done=%b err=%b want all 0",
                         k, en[k], addr[k], ov[k], ol[k], och[k], bsy[k], dn[k], er[k]);
            end
            vectors++;
            if (odata[k] !== '0) begin
                miscompares++;
                $display("FAIL reset.out_data dut%0d got %h want 0", k, odata[k][31:0]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        default_cfg(4);
        for (int n = 0; n < 5; n++) run_fetch(0, 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_channels();
        default_cfg(4);
        run_fetch(1, 2, 1'b0, 1'b0, 1'b0);
        run_fetch(2, 2, 1'b0, 1'b0, 1'b0);
        run_fetch(1, 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reject();
        int rch [3];
        int rlen [3];
        rch = '{3, 0, 2};
        rlen = '{2, 0, 3};
        m_nt[2] = 0;
        set_cfg();
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            start = 1'b1; ch_sel = CW'(rch[n]); flen = LW'(rlen[n]);
            @(posedge clk); #1;
            start = 1'b0;
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    vectors++;
                    if (er[k] !== (c == 0) || bsy[k] !== 1'b0 || en[k] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL reject.case%0d dut%0d cyc%0d got err=%b busy=%b en=%b want %b 0 0",
                                 n, k, c, er[k], bsy[k], en[k], c == 0);
                    end
                end
            end
        end
        m_nt[2] = 4;
        set_cfg();
        // Pointers must be untouched by the rejected starts.
        run_fetch(0, 2, 1'b0, 1'b0, 1'b0);
        run_fetch(2, 3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_collision();
        default_cfg(4);
        run_fetch(0, 2, 1'b1, 1'b1, 1'b0);
        run_fetch(0, 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_latency();
        default_cfg(8);
        run_fetch(2, 5, 1'b0, 1'b0, 1'b0);
        run_fetch(1, 15, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        random_cfg();
        for (int n = 0; n < 25; n++) begin
            run_fetch($urandom_range(0, 2), $urandom_range(1, 15), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0));
        end
    endtask

    task automatic test_midreset();
        default_cfg(4);
        run_fetch(0, 2, 1'b0, 1'b0, 1'b0);
        run_fetch(1, 2, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; ch_sel = 0; flen = 4;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (en[k] !== 1'b1) begin
                miscompares++;
                $display("FAIL midreset.issue dut%0d got en=%b want 1", k, en[k]);
            end
        end
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({en[k], addr[k], ov[k], ol[k], och[k], bsy[k], dn[k], er[k]} !== '0 ||
                odata[k] !== '0) begin
                miscompares++;
                $display("FAIL midreset.outputs dut%0d got en=%b addr=%0d v=%b busy=%b done=%b want all 0",
                         k, en[k], addr[k], ov[k], bsy[k], dn[k]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (dn[k] !== 1'b0 || ov[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL midreset.no_done dut%0d got done=%b valid=%b want 0 0", k, dn[k],
                             ov[k]);
                end
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < NCH; c++) m_ptr[c] = 0;
        run_fetch(0, 2, 1'b0, 1'b0, 1'b0);
        run_fetch(1, 2, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_channels();
        test_reject();
        test_collision();
        test_latency();
        test_random();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
